// File: rtl/mem_stage_lsu.sv
// Purpose: MEM-stage load/store unit, formats loads/stores for a 32-bit byte-strobed bus.
// Latency: 3 cycles minimum per access (IDLE, REQ, DONE); bus waits stretch REQ up to TIMEOUT cycles.
// Backpressure: StallM freezes the pipeline from acceptance through REQ; mem_ready completes, timeout aborts.
module mem_stage_lsu #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic             MemWriteM,
    input  logic             MemReadM,
    input  logic [2:0]       Funct3M,
    output logic [WIDTH-1:0] RDDataMemM,
    output logic             StallM,
    output logic             MisalignM,
    output logic             BusErrM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [WIDTH-1:0]   addr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [3:0]         wstrb_q;
    logic               bus_err_q;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;

    logic               acc_vld;
    logic               is_store;
    logic               is_byte;
    logic               is_half;
    logic               is_word;
    logic               misalign;
    logic [3:0]         st_strb;
    logic [WIDTH-1:0]   st_wdata;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [WIDTH-1:0]   ld_fmt;

    // Decode the incoming access: size class, alignment, store strobes and lane-replicated data.
    // Funct3 encodings 011/110/111 fall into the word class because only 00/01 in the low bits pick B/H.
    always_comb begin
        acc_vld  = MemWriteM | MemReadM;
        is_store = MemWriteM;
        is_byte  = (Funct3M[1:0] == 2'b00);
        is_half  = (Funct3M[1:0] == 2'b01);
        is_word  = !is_byte && !is_half;
        misalign = (is_half && ALUResultM[0]) || (is_word && (ALUResultM[1:0] != 2'b00));
        st_strb  = 4'b1111;
        st_wdata = WriteDataM;
        if (is_byte) begin
            st_strb  = 4'b0001 << ALUResultM[1:0];
            st_wdata = WIDTH'({4{WriteDataM[7:0]}});
        end else if (is_half) begin
            st_strb  = 4'b0011 << ALUResultM[1:0];
            st_wdata = WIDTH'({2{WriteDataM[15:0]}});
        end
    end

    // Format the returned bus word using the latched offset and funct3 of the access in flight.
    always_comb begin
        ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_fmt  = mem_rdata;
        if (f3_q[1:0] == 2'b00) begin
            ld_fmt = f3_q[2] ? {{(WIDTH-8){1'b0}}, ld_byte}
                             : {{(WIDTH-8){ld_byte[7]}}, ld_byte};
        end else if (f3_q[1:0] == 2'b01) begin
            ld_fmt = f3_q[2] ? {{(WIDTH-16){1'b0}}, ld_half}
                             : {{(WIDTH-16){ld_half[15]}}, ld_half};
        end
    end

    // Access FSM: latch the request in IDLE, hold the bus in REQ until ready or timeout, present result in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bus_err_q <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    bus_err_q <= 1'b0;
                    if (acc_vld && !misalign) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= is_store;
                        addr_q    <= {ALUResultM[WIDTH-1:2], 2'b00};
                        wdata_q   <= is_store ? st_wdata : '0;
                        wstrb_q   <= is_store ? st_strb : 4'b0000;
                        f3_q      <= Funct3M;
                        off_q     <= ALUResultM[1:0];
                    end
                end
                REQ: begin
                    // A ready in the last allowed cycle still completes normally.
                    if (mem_ready) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        result_q  <= mem_we_q ? '0 : ld_fmt;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        result_q  <= '0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    bus_err_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline-facing status: stall covers acceptance and the whole bus wait; result only visible in DONE.
    always_comb begin
        StallM     = ((state_q == IDLE) && acc_vld && !misalign) || (state_q == REQ);
        MisalignM  = (state_q == IDLE) && acc_vld && misalign;
        RDDataMemM = (state_q == DONE) ? result_q : '0;
        BusErrM    = bus_err_q;
        mem_req    = mem_req_q;
        mem_we     = mem_we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        mem_wstrb  = wstrb_q;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] ALUResultM = '0;
    logic [WIDTH-1:0] WriteDataM = '0;
    logic             MemWriteM = 1'b0;
    logic             MemReadM = 1'b0;
    logic [2:0]       Funct3M = 3'b000;
    logic [WIDTH-1:0] RDDataMemM;
    logic             StallM;
    logic             MisalignM;
    logic             BusErrM;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ready = 1'b0;
    logic [WIDTH-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        berr;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          req_cyc;
    } exp_t;

    exp_t sb[$];

    mem_stage_lsu #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .Funct3M    (Funct3M),
        .RDDataMemM (RDDataMemM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Drives one access starting at a negedge in IDLE, acts as the bus slave, and scores DONE against the queue.
    task automatic do_access(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic st, input logic ld,
                             input logic [31:0] rdata, input int ready_at, input exp_t e);
        exp_t x;
        int reqc = 0;
        int stallc = 0;
        bit done = 0;
        @(negedge clk);
        sb.push_back(e);
        ALUResultM = addr; WriteDataM = wd; MemWriteM = st; MemReadM = ld;
        Funct3M = f3; mem_rdata = rdata; mem_ready = 1'b0;
        #1;
        checks++;
        if (StallM !== 1'b1 || MisalignM !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: StallM=%b MisalignM=%b, required 1 and 0", name, StallM, MisalignM);
        end
        stallc = 1;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            if (mem_req) begin
                reqc++;
                checks++;
                if (mem_addr !== sb[0].addr || mem_we !== sb[0].we || mem_wstrb !== sb[0].strb ||
                    (sb[0].we && mem_wdata !== sb[0].wdata)) begin
                    errors++;
                    $display("FAIL %s bus: addr=%h we=%b strb=%b wdata=%h, required addr=%h we=%b strb=%b wdata=%h",
                             name, mem_addr, mem_we, mem_wstrb, mem_wdata,
                             sb[0].addr, sb[0].we, sb[0].strb, sb[0].wdata);
                end
                mem_ready = (reqc == ready_at);
            end else begin
                mem_ready = 1'b0;
            end
            if (StallM) begin
                stallc++;
            end else begin
                done = 1;
                x = sb.pop_front();
                checks++;
                if (RDDataMemM !== x.rd) begin
                    errors++;
                    $display("FAIL %s rddata: got %h, required %h", name, RDDataMemM, x.rd);
                end
                checks++;
                if (BusErrM !== x.berr) begin
                    errors++;
                    $display("FAIL %s buserr: got %b, required %b", name, BusErrM, x.berr);
                end
                checks++;
                if (reqc != x.req_cyc) begin
                    errors++;
                    $display("FAIL %s req_cycles: got %0d, required %0d", name, reqc, x.req_cyc);
                end
                checks++;
                if (stallc != x.req_cyc + 1) begin
                    errors++;
                    $display("FAIL %s stall_cycles: got %0d, required %0d", name, stallc, x.req_cyc + 1);
                end
            end
        end
        MemWriteM = 1'b0; MemReadM = 1'b0; mem_ready = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s no_completion: StallM still %b after 64 cycles, required completion", name, StallM);
            if (sb.size() > 0) x = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'b0 || BusErrM !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b we=%b strb=%b berr=%b, required all 0", mem_req, mem_we, mem_wstrb, BusErrM);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
        end
        checks++;
        if (StallM !== 1'b0 || MisalignM !== 1'b0 || RDDataMemM !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: stall=%b mis=%b rd=%h, required 0", StallM, MisalignM, RDDataMemM);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0 || mem_req !== 1'b0 || RDDataMemM !== 32'h0) begin
            errors++;
            $display("FAIL post_reset: stall=%b req=%b rd=%h, required 0", StallM, mem_req, RDDataMemM);
        end
    endtask

    task automatic test_ready_ignored();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || StallM !== 1'b0 || BusErrM !== 1'b0 || RDDataMemM !== 32'h0) begin
                errors++;
                $display("FAIL idle_ready: req=%b stall=%b berr=%b rd=%h, required 0", mem_req, StallM, BusErrM, RDDataMemM);
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_loads();
        do_access("lw",  3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 1, '{32'hDEADBEEF, 1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 1});
        do_access("lb",  3'b000, 32'h103, 32'h0, 0, 1, 32'h80FFFFFF, 1, '{32'hFFFFFF80, 1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 1});
        do_access("lbu", 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FFFFFF, 1, '{32'h00000080, 1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 1});
        do_access("lb_pos", 3'b000, 32'h101, 32'h0, 0, 1, 32'h00007F00, 1, '{32'h0000007F, 1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 1});
        do_access("lh",  3'b001, 32'h102, 32'h0, 0, 1, 32'h80017FFF, 1, '{32'hFFFF8001, 1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 1});
        do_access("lhu", 3'b101, 32'h102, 32'h0, 0, 1, 32'h80017FFF, 1, '{32'h00008001, 1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 1});
        do_access("lw011", 3'b011, 32'h104, 32'h0, 0, 1, 32'h11223344, 2, '{32'h11223344, 1'b0, 32'h104, 1'b0, 4'h0, 32'h0, 2});
    endtask

    task automatic test_stores();
        do_access("sh", 3'b001, 32'h202, 32'h1234ABCD, 1, 0, 32'hFFFFFFFF, 1, '{32'h0, 1'b0, 32'h200, 1'b1, 4'b1100, 32'hABCDABCD, 1});
        do_access("sb", 3'b000, 32'h101, 32'h0000005A, 1, 0, 32'hFFFFFFFF, 1, '{32'h0, 1'b0, 32'h100, 1'b1, 4'b0010, 32'h5A5A5A5A, 1});
        do_access("sw_both", 3'b010, 32'h300, 32'hCAFEF00D, 1, 1, 32'h99999999, 3, '{32'h0, 1'b0, 32'h300, 1'b1, 4'b1111, 32'hCAFEF00D, 3});
    endtask

    task automatic test_misalign();
        logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b110};
        logic [31:0] ads [3] = '{32'h101, 32'h103, 32'h302};
        logic        sts [3] = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ALUResultM = ads[k]; Funct3M = f3s[k]; MemWriteM = sts[k]; MemReadM = !sts[k];
            WriteDataM = 32'h13572468;
            #1;
            checks++;
            if (MisalignM !== 1'b1 || StallM !== 1'b0 || RDDataMemM !== 32'h0) begin
                errors++;
                $display("FAIL misalign_%0d: mis=%b stall=%b rd=%h, required 1/0/0", k, MisalignM, StallM, RDDataMemM);
            end
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checks++;
                if (mem_req !== 1'b0 || MisalignM !== 1'b1) begin
                    errors++;
                    $display("FAIL misalign_noreq_%0d: req=%b mis=%b, required 0/1", k, mem_req, MisalignM);
                end
            end
            MemWriteM = 1'b0; MemReadM = 1'b0;
        end
    endtask

    task automatic test_timeout();
        do_access("lw_timeout", 3'b010, 32'h180, 32'h0, 0, 1, 32'h55555555, 0, '{32'h0, 1'b1, 32'h180, 1'b0, 4'h0, 32'h0, TIMEOUT});
        @(negedge clk);
        checks++;
        if (BusErrM !== 1'b0 || RDDataMemM !== 32'h0) begin
            errors++;
            $display("FAIL buserr_one_cycle: berr=%b rd=%h, required 0/0", BusErrM, RDDataMemM);
        end
        do_access("lw_ready_last", 3'b010, 32'h184, 32'h0, 0, 1, 32'h0BADF00D, TIMEOUT, '{32'h0BADF00D, 1'b0, 32'h184, 1'b0, 4'h0, 32'h0, TIMEOUT});
    endtask

    task automatic test_reset_mid_req();
        int reqc = 0;
        bit hit = 0;
        @(negedge clk);
        ALUResultM = 32'h400; WriteDataM = 32'h87654321; Funct3M = 3'b010;
        MemWriteM = 1'b1; MemReadM = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (mem_req) reqc++;
            if (reqc == 3) begin
                hit = 1;
                rst_n = 1'b0;
                MemWriteM = 1'b0;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_req_setup: reached %0d REQ cycles, required 3", reqc);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || BusErrM !== 1'b0 || StallM !== 1'b0 || mem_we !== 1'b0 ||
            mem_wstrb !== 4'b0 || RDDataMemM !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_req: req=%b berr=%b stall=%b we=%b strb=%b rd=%h, required all 0",
                     mem_req, BusErrM, StallM, mem_we, mem_wstrb, RDDataMemM);
        end
        rst_n = 1'b1;
        do_access("lw_after_reset", 3'b010, 32'h104, 32'h0, 0, 1, 32'hA5A5C3C3, 1, '{32'hA5A5C3C3, 1'b0, 32'h104, 1'b0, 4'h0, 32'h0, 1});
    endtask

    task automatic test_back_to_back();
        do_access("b2b_lw",  3'b010, 32'h010, 32'h0, 0, 1, 32'h01020304, 2, '{32'h01020304, 1'b0, 32'h010, 1'b0, 4'h0, 32'h0, 2});
        do_access("b2b_lbu", 3'b100, 32'h012, 32'h0, 0, 1, 32'hA1B2C3D4, 2, '{32'h000000B2, 1'b0, 32'h010, 1'b0, 4'h0, 32'h0, 2});
        do_access("b2b_sb",  3'b000, 32'h013, 32'hFFFFFF7E, 1, 0, 32'h0, 1, '{32'h0, 1'b0, 32'h010, 1'b1, 4'b1000, 32'h7E7E7E7E, 1});
    endtask

    initial begin
        test_reset();
        test_ready_ignored();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the datapath and address width.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of REQ cycles allowed before a bus error.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 ALUResultM  input  WIDTH  SHALL carry the byte address of the access.
REQ-006 WriteDataM  input  WIDTH  SHALL carry the store data, with the value in its low bits.
REQ-007 MemWriteM, MemReadM  input  1 each  SHALL be the store and load requests.
REQ-008 Funct3M  input  3  SHALL encode size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 RDDataMemM  output  WIDTH  SHALL carry the formatted load result that feeds the MEM/WB register.
REQ-010 StallM  output  1  SHALL freeze the PC, the IF/ID, ID/EX and EX/MEM registers, and the MEM/WB register while high.
REQ-011 MisalignM, BusErrM  output  1 each  SHALL be the fault flags.
REQ-012 mem_req, mem_we  output  1 each  SHALL be the registered bus request and write enable.
REQ-013 mem_addr  output  WIDTH  SHALL be the word-aligned bus address, with bits [1:0] equal to 0.
REQ-014 mem_wdata  output  WIDTH  and mem_wstrb  output  4  SHALL carry the lane-replicated store data and the byte strobes.
REQ-015 mem_ready  input  1  and mem_rdata  input  WIDTH  SHALL carry the bus completion and the read word.

Function
REQ-016 The FSM SHALL have three states: IDLE, REQ, DONE.
REQ-017 An access SHALL be valid when MemWriteM or MemReadM is high; if both are high, the access SHALL be a store and the read SHALL be ignored.
REQ-018 An access SHALL be misaligned when H/HU has addr[0]=1, or W has addr[1:0]!=00.
REQ-019 Funct3 values 011, 110 and 111 SHALL be treated as W.
REQ-020 In IDLE with a valid, aligned access:
- StallM=1, combinational, in the same cycle.
- Address, strobes, wdata, funct3 and direction are latched.
- Next state is REQ.
REQ-021 In IDLE with a valid, misaligned access:
- No bus request is issued.
- MisalignM=1, combinational.
- StallM=0.
- RDDataMemM=0.
REQ-022 In IDLE with no valid access: StallM=0, RDDataMemM=0, no bus activity.
REQ-023 In REQ:
- mem_req=1 and StallM=1.
- mem_we, mem_addr, mem_wdata and mem_wstrb are held stable.
- The timeout counter increments each cycle.
REQ-024 In REQ with mem_ready=1:
- For a load, the formatted mem_rdata is captured into the result register.
- Next state is DONE.
- mem_req=0 from the next cycle.
REQ-025 In REQ, if mem_ready=0 at counter value TIMEOUT-1:
- Next state is DONE.
- The result register is set to 0.
- BusErrM is set for the DONE cycle only.
REQ-026 In DONE:
- StallM=0 and mem_req=0.
- RDDataMemM = the result register (0 for stores).
- Next state is IDLE; the counter clears.
- Minimum load/store latency is therefore 3 cycles (IDLE, REQ, DONE) with zero-wait memory.
REQ-027 Load formatting SHALL select the byte/half by addr[1:0]:
- B and H sign-extend to WIDTH.
- BU and HU zero-extend.
- W passes the word through.
REQ-028 Store strobes SHALL be:
- SB: 0001 << addr[1:0].
- SH: 0011 << addr[1:0].
- SW: 1111.
REQ-029 Store wdata SHALL be the byte replicated into 4 lanes (SB), the halfword into 2 lanes (SH), or the word unchanged (SW).
REQ-030 For loads, mem_we=0 and mem_wstrb=0000.
REQ-031 A mem_ready seen in IDLE or DONE SHALL be ignored.
REQ-032 A mem_ready seen in the same cycle as the timeout SHALL win: the access completes normally and BusErrM=0.

Reset
REQ-033 When rst_n=0 at a clock edge:
- State becomes IDLE; counter, result register, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb and BusErrM become 0.
- This holds from any state, including mid-REQ: mem_req falls after that edge, with no completion and no BusErrM.
REQ-034 During and after reset, until a valid access arrives: StallM=0, MisalignM=0, RDDataMemM=0.

Verification
REQ-035 LW, addr 0x100, mem_rdata 0xDEADBEEF, mem_ready high in the first REQ cycle -> StallM high for 2 cycles; DONE cycle RDDataMemM=0xDEADBEEF; mem_addr=0x100.
REQ-036 LB, addr 0x103, mem_rdata 0x80FF_FFFF -> RDDataMemM=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-037 SH, addr 0x202, WriteDataM 0x1234ABCD -> mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1, mem_addr=0x200.
REQ-038 LW, addr 0x101 -> MisalignM=1, StallM=0, mem_req never asserted, RDDataMemM=0.
REQ-039 LW with mem_ready held low, TIMEOUT=16 -> mem_req high for exactly 16 cycles, then BusErrM=1 for 1 cycle and RDDataMemM=0; a second run with mem_ready arriving in the 16th cycle -> normal completion and BusErrM=0.
REQ-040 rst_n driven low in the 3rd REQ cycle of an SW -> mem_req=0 after that edge, state IDLE, no BusErrM; the next LW completes normally.
